// File: rtl/amstrad_ram_arbiter.sv
// Shares the zsdram CPU port between the ROM loader byte stream and the CPC motherboard.
// Loader bytes are decoded into ROM slots and queued; one SDRAM operation is issued per clkref slot.
module amstrad_ram_arbiter #(
    parameter int FIFO_AW = 2,
    parameter int ADDR_W  = 23
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              clkref,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [24:0]       dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_full,
    output logic              dl_ovf,
    input  logic              cpu_r,
    input  logic              cpu_w,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [7:0]        cpu_din,
    input  logic [1:0]        cpu_bank,
    output logic              cpu_ack,
    output logic              sd_oe,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [1:0]        sd_bank,
    output logic [7:0]        sd_din
);

    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int ENTRY_W = 2 + ADDR_W + 8;

    typedef enum logic [1:0] {IDLE, DL_SLOT, CPU_SLOT} state_t;

    state_t              state;
    logic [10:0]         blk;
    logic                dec_valid;
    logic [1:0]          dec_bank;
    logic [ADDR_W-1:0]   dec_addr;

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [FIFO_AW:0]    wptr;
    logic [FIFO_AW:0]    rptr;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;
    logic [1:0]          head_bank;
    logic [ADDR_W-1:0]   head_addr;
    logic [7:0]          head_data;

    // Each 16 KB loader block maps onto one of three ROM slots in bank 0 or bank 1.
    always_comb begin
        blk       = dl_addr[24:14];
        dec_valid = 1'b1;
        dec_bank  = 2'd0;
        dec_addr  = '0;
        case (blk)
            11'd0, 11'd3: dec_addr = ADDR_W'({9'h000, dl_addr[13:0]});
            11'd1, 11'd4: dec_addr = ADDR_W'({9'h100, dl_addr[13:0]});
            11'd2, 11'd5: dec_addr = ADDR_W'({9'h107, dl_addr[13:0]});
            default:      dec_valid = 1'b0;
        endcase
        if (blk >= 11'd3) dec_bank = 2'd1;
    end

    assign fifo_empty = (wptr == rptr);
    assign dl_full    = ((wptr ^ rptr) == {1'b1, {FIFO_AW{1'b0}}});
    assign pop        = clkref & ~fifo_empty;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign push       = dl_wr & dec_valid & (~dl_full | pop);

    assign head      = mem[rptr[FIFO_AW-1:0]];
    assign head_bank = head[ENTRY_W-1 -: 2];
    assign head_addr = head[8 +: ADDR_W];
    assign head_data = head[7:0];

    always_ff @(posedge clk_sys) begin
        if (push) mem[wptr[FIFO_AW-1:0]] <= {dec_bank, dec_addr, dl_data};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wptr   <= '0;
            rptr   <= '0;
            dl_ovf <= 1'b0;
        end else begin
            if (push) wptr <= wptr + (FIFO_AW+1)'(1);
            if (pop)  rptr <= rptr + (FIFO_AW+1)'(1);
            if (dl_wr & dec_valid & dl_full & ~pop) dl_ovf <= 1'b1;
        end
    end

    // Slot decisions happen only on clkref; outputs then hold for the whole slot.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= IDLE;
            cpu_ack <= 1'b0;
            sd_oe   <= 1'b0;
            sd_we   <= 1'b0;
            sd_addr <= '0;
            sd_bank <= 2'd0;
            sd_din  <= 8'd0;
        end else if (clkref) begin
            cpu_ack <= 1'b0;
            if (!fifo_empty) begin
                state   <= DL_SLOT;
                sd_oe   <= 1'b0;
                sd_we   <= 1'b1;
                sd_addr <= head_addr;
                sd_bank <= head_bank;
                sd_din  <= head_data;
            end else if (!dl_active && (cpu_r || cpu_w)) begin
                state   <= CPU_SLOT;
                cpu_ack <= 1'b1;
                sd_oe   <= cpu_r;
                sd_we   <= cpu_w & ~cpu_r;
                sd_addr <= cpu_a;
                sd_bank <= cpu_bank;
                sd_din  <= cpu_din;
            end else begin
                state <= IDLE;
                sd_oe <= 1'b0;
                sd_we <= 1'b0;
            end
        end else if (state == CPU_SLOT) begin
            cpu_ack <= 1'b0;
        end
    end

endmodule
